instr_fetch: RTL and testbench

Instruction source for the CPU core. Holds a small program memory, a program counter and a fetch state machine. Drives the core's 8-bit instruction input one word per fetch request and accepts jump redirects from the Controller's immediate field. Program memory is loaded through a write port while the block is idle. Execution stops on a halt opcode.

---
 rtl/instr_fetch.sv | 143 ++++++++++++++
 tb/tb_instr_fetch.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: program memory, program counter and fetch FSM feeding the core's IR.
// Optional breakpoint halt is enabled by defining IFETCH_BREAKPOINT_EN.
module instr_fetch #(
  parameter int unsigned ADDR_W  = 4,
  parameter logic [7:0]  HALT_OP = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [7:0]        prog_data,
  input  logic              run,
  input  logic              fetch_req,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
`ifdef IFETCH_BREAKPOINT_EN
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
`endif
  output logic [7:0]        instruction,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [DATA_W-1:0] instr_q, instr_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              halted_q, halted_d;

  logic [DATA_W-1:0] fetch_word_c;
  logic [ADDR_W-1:0] pc_tgt_c;
  logic              bp_hit_c;

  assign fetch_word_c = mem_q[pc_q];
  // A jump redirect takes priority over the current PC for the next fetch.
  assign pc_tgt_c     = jump_en ? jump_addr : pc_q;

`ifdef IFETCH_BREAKPOINT_EN
  assign bp_hit_c = fetch_req && bp_en && (pc_tgt_c == bp_addr);
`else
  assign bp_hit_c = 1'b0;
`endif

  // Program memory: not reset, writable only while idle.
  always_ff @(posedge clk) begin
    if (reset && (state_q == S_IDLE) && prog_we) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        state_d = (fetch_word_c == HALT_OP) ? S_HALT : S_HOLD;
      end
      S_HOLD: begin
        if (bp_hit_c) begin
          state_d = S_HALT;
        end else if (fetch_req) begin
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    instr_d  = instr_q;
    valid_d  = valid_q;
    pc_d     = pc_q;
    halted_d = halted_q;
    case (state_q)
      S_FETCH: begin
        instr_d = fetch_word_c;
        valid_d = 1'b1;
        pc_d    = pc_q + ADDR_W'(1);
        if (fetch_word_c == HALT_OP) halted_d = 1'b1;
      end
      S_HOLD: begin
        pc_d = pc_tgt_c;
        if (bp_hit_c) halted_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      instr_q  <= '0;
      valid_q  <= 1'b0;
      pc_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: per-cycle vector table plus directed multi-cycle sequences.
module tb_instr_fetch;

  localparam int unsigned ADDR_W = 4;

  logic              clk;
  logic              reset;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [7:0]        prog_data;
  logic              run;
  logic              fetch_req;
  logic              jump_en;
  logic [ADDR_W-1:0] jump_addr;
  logic              bp_en;
  logic [ADDR_W-1:0] bp_addr;
  logic [7:0]        instruction;
  logic              instr_valid;
  logic [ADDR_W-1:0] pc;
  logic              halted;

  int checks;
  int failures;

  instr_fetch #(.ADDR_W(ADDR_W), .HALT_OP(8'hFF)) dut (
    .clk         (clk),
    .reset       (reset),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .run         (run),
    .fetch_req   (fetch_req),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
`ifdef IFETCH_BREAKPOINT_EN
    .bp_en       (bp_en),
    .bp_addr     (bp_addr),
`endif
    .instruction (instruction),
    .instr_valid (instr_valid),
    .pc          (pc),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              rst_n;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [7:0]        wdata;
    logic              go;
    logic              freq;
    logic              jen;
    logic [ADDR_W-1:0] jaddr;
    logic [7:0]        e_instr;
    logic              e_valid;
    logic [ADDR_W-1:0] e_pc;
    logic              e_halt;
  } vec_t;

  localparam int NVEC = 26;
  vec_t vecs [NVEC];

  // Drive one cycle of inputs, clock it, and settle past the edge.
  task automatic cyc(input logic r, input logic we, input logic [ADDR_W-1:0] wa,
                     input logic [7:0] wd, input logic go, input logic fr,
                     input logic je, input logic [ADDR_W-1:0] ja);
    reset = r; prog_we = we; prog_addr = wa; prog_data = wd;
    run = go; fetch_req = fr; jump_en = je; jump_addr = ja;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, '0, 8'h00, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic chk(input string name, input logic [7:0] ei, input logic ev,
                     input logic [ADDR_W-1:0] ep, input logic eh);
    checks++;
    if (instruction !== ei || instr_valid !== ev || pc !== ep || halted !== eh) begin
      failures++;
      $display("FAIL %s: got instr=%h valid=%b pc=%0d halted=%b, want instr=%h valid=%b pc=%0d halted=%b",
               name, instruction, instr_valid, pc, halted, ei, ev, ep, eh);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    bp_en = 1'b0; bp_addr = '0;
    reset = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    run = 1'b0; fetch_req = 1'b0; jump_en = 1'b0; jump_addr = '0;

    //          rst we  wa  wd    go fr je ja     instr valid pc halt
    vecs[0]  = '{1'b0,1'b0,4'd0,8'h00,1'b0,1'b0,1'b0,4'd0, 8'h00,1'b0,4'd0,1'b0};
    vecs[1]  = '{1'b0,1'b0,4'd0,8'h00,1'b0,1'b0,1'b0,4'd0, 8'h00,1'b0,4'd0,1'b0};
    vecs[2]  = '{1'b1,1'b1,4'd0,8'h12,1'b0,1'b0,1'b0,4'd0, 8'h00,1'b0,4'd0,1'b0};
    vecs[3]  = '{1'b1,1'b1,4'd1,8'h34,1'b0,1'b0,1'b0,4'd0, 8'h00,1'b0,4'd0,1'b0};
    vecs[4]  = '{1'b1,1'b1,4'd2,8'hFF,1'b0,1'b0,1'b0,4'd0, 8'h00,1'b0,4'd0,1'b0};
    vecs[5]  = '{1'b1,1'b0,4'd0,8'h00,1'b1,1'b0,1'b0,4'd0, 8'h00,1'b0,4'd0,1'b0};
    vecs[6]  = '{1'b1,1'b0,4'd0,8'h00,1'b0,1'b0,1'b0,4'd0, 8'h12,1'b1,4'd1,1'b0};
    vecs[7]  = '{1'b1,1'b0,4'd0,8'h00,1'b0,1'b1,1'b0,4'd0, 8'h12,1'b1,4'd1,1'b0};
    vecs[8]  = '{1'b1,1'b0,4'd0,8'h00,1'b0,1'b0,1'b0,4'd0, 8'h34,1'b1,4'd2,1'b0};
    vecs[9]  = '{1'b1,1'b0,4'd0,8'h00,1'b0,1'b1,1'b0,4'd0, 8'h34,1'b1,4'd2,1'b0};
    vecs[10] = '{1'b1,1'b0,4'd0,8'h00,1'b0,1'b0,1'b0,4'd0, 8'hFF,1'b1,4'd3,1'b1};
    vecs[11] = '{1'b1,1'b0,4'd0,8'h00,1'b0,1'b1,1'b1,4'd7, 8'hFF,1'b1,4'd3,1'b1};
    vecs[12] = '{1'b1,1'b1,4'd0,8'h55,1'b1,1'b1,1'b0,4'd0, 8'hFF,1'b1,4'd3,1'b1};
    vecs[13] = '{1'b0,1'b0,4'd0,8'h00,1'b0,1'b0,1'b0,4'd0, 8'h00,1'b0,4'd0,1'b0};
    vecs[14] = '{1'b1,1'b0,4'd0,8'h00,1'b1,1'b0,1'b0,4'd0, 8'h00,1'b0,4'd0,1'b0};
    vecs[15] = '{1'b1,1'b0,4'd0,8'h00,1'b0,1'b0,1'b0,4'd0, 8'h12,1'b1,4'd1,1'b0};
    vecs[16] = '{1'b0,1'b0,4'd0,8'h00,1'b0,1'b0,1'b0,4'd0, 8'h00,1'b0,4'd0,1'b0};
    vecs[17] = '{1'b1,1'b1,4'd0,8'h01,1'b0,1'b0,1'b0,4'd0, 8'h00,1'b0,4'd0,1'b0};
    vecs[18] = '{1'b1,1'b1,4'd9,8'hA5,1'b0,1'b0,1'b0,4'd0, 8'h00,1'b0,4'd0,1'b0};
    vecs[19] = '{1'b1,1'b0,4'd0,8'h00,1'b1,1'b0,1'b0,4'd0, 8'h00,1'b0,4'd0,1'b0};
    vecs[20] = '{1'b1,1'b0,4'd0,8'h00,1'b0,1'b0,1'b0,4'd0, 8'h01,1'b1,4'd1,1'b0};
    vecs[21] = '{1'b1,1'b0,4'd0,8'h00,1'b0,1'b1,1'b1,4'd9, 8'h01,1'b1,4'd9,1'b0};
    vecs[22] = '{1'b1,1'b0,4'd0,8'h00,1'b0,1'b0,1'b0,4'd0, 8'hA5,1'b1,4'd10,1'b0};
    vecs[23] = '{1'b1,1'b0,4'd0,8'h00,1'b0,1'b0,1'b1,4'd3, 8'hA5,1'b1,4'd3,1'b0};
    vecs[24] = '{1'b0,1'b0,4'd0,8'h00,1'b0,1'b0,1'b0,4'd0, 8'h00,1'b0,4'd0,1'b0};
    vecs[25] = '{1'b1,1'b0,4'd0,8'h00,1'b0,1'b0,1'b1,4'd5, 8'h00,1'b0,4'd0,1'b0};

    @(negedge clk);
    for (int i = 0; i < NVEC; i++) begin
      cyc(vecs[i].rst_n, vecs[i].we, vecs[i].waddr, vecs[i].wdata,
          vecs[i].go, vecs[i].freq, vecs[i].jen, vecs[i].jaddr);
      chk($sformatf("vec%0d", i), vecs[i].e_instr, vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_halt);
    end

    // PC wrap from the top of memory back to address 0.
    cyc(1'b0, 1'b0, '0, 8'h00, 1'b0, 1'b0, 1'b0, '0);
    cyc(1'b1, 1'b1, 4'd15, 8'h0F, 1'b0, 1'b0, 1'b0, '0);
    cyc(1'b1, 1'b1, 4'd0,  8'h10, 1'b0, 1'b0, 1'b0, '0);
    cyc(1'b1, 1'b0, '0, 8'h00, 1'b1, 1'b0, 1'b0, '0);
    idle();
    chk("wrap_first", 8'h10, 1'b1, 4'd1, 1'b0);
    cyc(1'b1, 1'b0, '0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd15);
    cyc(1'b1, 1'b0, '0, 8'h00, 1'b0, 1'b1, 1'b0, '0);
    idle();
    chk("wrap_top", 8'h0F, 1'b1, 4'd0, 1'b0);
    cyc(1'b1, 1'b0, '0, 8'h00, 1'b0, 1'b1, 1'b0, '0);
    idle();
    chk("wrap_zero", 8'h10, 1'b1, 4'd1, 1'b0);

    // Reset in HOLD at pc=5, then re-run from retained memory.
    cyc(1'b0, 1'b0, '0, 8'h00, 1'b0, 1'b0, 1'b0, '0);
    for (int a = 1; a <= 5; a++) cyc(1'b1, 1'b1, 4'(a), 8'(8'h20 + a), 1'b0, 1'b0, 1'b0, '0);
    cyc(1'b1, 1'b0, '0, 8'h00, 1'b1, 1'b0, 1'b0, '0);
    idle();
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 1'b0, '0, 8'h00, 1'b0, 1'b1, 1'b0, '0);
      idle();
    end
    chk("hold_pc5", 8'h24, 1'b1, 4'd5, 1'b0);
    cyc(1'b0, 1'b0, '0, 8'h00, 1'b0, 1'b0, 1'b0, '0);
    chk("midrun_reset", 8'h00, 1'b0, 4'd0, 1'b0);
    cyc(1'b1, 1'b0, '0, 8'h00, 1'b1, 1'b0, 1'b0, '0);
    idle();
    chk("rerun", 8'h10, 1'b1, 4'd1, 1'b0);

`ifdef IFETCH_BREAKPOINT_EN
    // Breakpoint at address 2 halts before fetching it.
    cyc(1'b0, 1'b0, '0, 8'h00, 1'b0, 1'b0, 1'b0, '0);
    cyc(1'b1, 1'b1, 4'd2, 8'h22, 1'b0, 1'b0, 1'b0, '0);
    bp_en = 1'b1; bp_addr = 4'd2;
    cyc(1'b1, 1'b0, '0, 8'h00, 1'b1, 1'b0, 1'b0, '0);
    idle();
    chk("bp_first", 8'h10, 1'b1, 4'd1, 1'b0);
    cyc(1'b1, 1'b0, '0, 8'h00, 1'b0, 1'b1, 1'b0, '0);
    idle();
    chk("bp_second", 8'h21, 1'b1, 4'd2, 1'b0);
    cyc(1'b1, 1'b0, '0, 8'h00, 1'b0, 1'b1, 1'b0, '0);
    chk("bp_halt", 8'h21, 1'b1, 4'd2, 1'b1);
    idle();
    chk("bp_stay", 8'h21, 1'b1, 4'd2, 1'b1);
    bp_en = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
